// File: rtl/uart_rx_fifo_if.sv
// Bundles the push, pop, status and overflow-clear signals of the receive
// FIFO. The master side is the UART receiver and consumer. The slave side is
// the FIFO itself.
interface uart_rx_fifo_if #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
);
  logic [DBIT-1:0] wr_data;
  logic            wr_tick;
  logic            rd_en;
  logic            overflow_clr;
  logic [DBIT-1:0] rd_data;
  logic            rd_valid;
  logic            empty;
  logic            full;
  logic            almost_full;
  logic [ADDR_W:0] count;
  logic            overflow;

  modport master (
    output wr_data, wr_tick, rd_en, overflow_clr,
    input  rd_data, rd_valid, empty, full, almost_full, count, overflow
  );

  modport slave (
    input  wr_data, wr_tick, rd_en, overflow_clr,
    output rd_data, rd_valid, empty, full, almost_full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO for a UART. It captures a word on each receiver done
// tick and stores up to 2**ADDR_W words in arrival order. Words leave through
// a registered pop port. The status flags are decoded only from the
// registered occupancy count, so no input has a combinational path to an
// output.
module uart_rx_fifo #(
  parameter int DBIT     = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic             clk,
  input  logic             reset,
  uart_rx_fifo_if.slave    bus
);
  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W + 1)'(AF_LEVEL);

  logic [DBIT-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic [DBIT-1:0]   rd_data_q;
  logic              rd_valid_q;
  logic              overflow_q;

  logic              is_empty;
  logic              is_full;
  logic              push;
  logic              pop;
  logic              drop;

  // Decode the flags from the stored count and qualify the push/pop requests.
  // NOTE: every signal gets a default first, so a missed branch cannot infer a latch.
  always_comb begin
    is_empty = 1'b0;
    is_full  = 1'b0;
    pop      = 1'b0;
    push     = 1'b0;
    drop     = 1'b0;

    is_empty = (count_q == '0);
    is_full  = (count_q == FULL_CNT);
    // A pop on an empty FIFO is ignored. There is no bypass from the write port.
    pop      = bus.rd_en && !is_empty;
    // When the FIFO is full, a push is accepted only if a pop frees a slot in the same cycle.
    push     = bus.wr_tick && (!is_full || pop);
    drop     = bus.wr_tick && is_full && !pop;
  end

  // Write the storage array. It has no reset because stale words are unreachable once the pointers are cleared.
  // NOTE: the memory is deliberately left out of reset so it can map onto plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Advance the pointers and track occupancy. Pointers wrap naturally modulo the depth.
  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Register the popped word. On a full push+pop to the same slot, this returns the old head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop;
      if (pop) begin
        rd_data_q <= mem[rd_ptr];
      end
    end
  end

  // Sticky overflow flag. A dropped push wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (bus.overflow_clr) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.count       = count_q;
  assign bus.empty       = is_empty;
  assign bus.full        = is_full;
  assign bus.almost_full = (count_q >= AF_CNT);
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed test of uart_rx_fifo (DBIT=8, ADDR_W=4, AF_LEVEL=12).
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic [7:0] q[$];
  logic [7:0] v;
  logic [7:0] exp_d;
  logic       re;
  int         lag;

  uart_rx_fifo_if #(.DBIT(8), .ADDR_W(4)) bus ();

  uart_rx_fifo #(.DBIT(8), .ADDR_W(4), .AF_LEVEL(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are driven at the negedge, and outputs are checked 1 time unit after the posedge.
  task automatic step(input logic wt, input logic [7:0] wd, input logic rd, input logic oc);
    @(negedge clk);
    bus.wr_tick      = wt;
    bus.wr_data      = wd;
    bus.rd_en        = rd;
    bus.overflow_clr = oc;
    @(posedge clk);
    #1;
    bus.wr_tick      = 1'b0;
    bus.rd_en        = 1'b0;
    bus.overflow_clr = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_data"}, bus.rd_data, 0);
    check({tag, "_rd_valid"}, bus.rd_valid, 0);
    check({tag, "_empty"}, bus.empty, 1);
    check({tag, "_full"}, bus.full, 0);
    check({tag, "_af"}, bus.almost_full, 0);
    check({tag, "_count"}, bus.count, 0);
    check({tag, "_ovf"}, bus.overflow, 0);
  endtask

  initial begin
    bus.wr_tick      = 1'b0;
    bus.wr_data      = 8'h00;
    bus.rd_en        = 1'b0;
    bus.overflow_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("rst");

    // Push 3 slow words, then pop them back-to-back.
    for (int i = 0; i < 3; i++) begin
      v = 8'h41 + 8'(i);
      step(1'b1, v, 1'b0, 1'b0);
      repeat (15) step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    check("slow_count", bus.count, 3);
    check("slow_empty", bus.empty, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      exp_d = 8'h41 + 8'(i);
      check("slow_valid", bus.rd_valid, 1);
      check("slow_data", bus.rd_data, exp_d);
    end
    check("slow_empty_end", bus.empty, 1);
    check("slow_count_end", bus.count, 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("idle_valid", bus.rd_valid, 0);
    check("idle_hold", bus.rd_data, 8'h43);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("empty_pop_valid", bus.rd_valid, 0);
    check("empty_pop_hold", bus.rd_data, 8'h43);

    // Fill with 0x00..0x0F and watch almost_full and full.
    for (int i = 0; i < 16; i++) begin
      v = 8'(i);
      step(1'b1, v, 1'b0, 1'b0);
      check("fill_count", bus.count, i + 1);
      check("fill_af", bus.almost_full, (i + 1 >= 12) ? 1 : 0);
      check("fill_full", bus.full, (i == 15) ? 1 : 0);
    end
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    check("drop_ovf", bus.overflow, 1);
    check("drop_count", bus.count, 16);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_ovf", bus.overflow, 0);

    // Full with push and pop in the same cycle: the old head comes out and count stays at 16.
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    check("fullpp_valid", bus.rd_valid, 1);
    check("fullpp_data", bus.rd_data, 8'h00);
    check("fullpp_count", bus.count, 16);
    check("fullpp_ovf", bus.overflow, 0);
    for (int i = 1; i < 17; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      exp_d = (i == 16) ? 8'hAA : 8'(i);
      check("drain_data", bus.rd_data, exp_d);
      check("drain_valid", bus.rd_valid, 1);
    end
    check("drain_empty", bus.empty, 1);

    // Empty with push and pop in the same cycle: the pop is ignored.
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("emptypp_valid", bus.rd_valid, 0);
    check("emptypp_count", bus.count, 1);
    check("emptypp_hold", bus.rd_data, 8'hAA);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("emptypp_data", bus.rd_data, 8'h55);
    check("emptypp_count0", bus.count, 0);

    // Wrap-around: 40 pushes, with pops that trail behind by a varying lag.
    for (int i = 0; i < 40; i++) begin
      v   = 8'(i * 37 + 5);
      lag = i % 5;
      re  = (q.size() > lag);
      step(1'b1, v, re, 1'b0);
      if (re) begin
        exp_d = q.pop_front();
        check("wrap_valid", bus.rd_valid, 1);
        check("wrap_data", bus.rd_data, exp_d);
      end
      q.push_back(v);
      check("wrap_count", bus.count, q.size());
    end
    while (q.size() > 0) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      exp_d = q.pop_front();
      check("wrap_drain", bus.rd_data, exp_d);
    end
    check("wrap_empty", bus.empty, 1);

    // A drop and a clear in the same cycle: the set wins.
    for (int i = 0; i < 16; i++) begin
      v = 8'h80 + 8'(i);
      step(1'b1, v, 1'b0, 1'b0);
    end
    check("ovf2_full", bus.full, 1);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    check("ovf_set_wins", bus.overflow, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr_alone", bus.overflow, 0);

    // Drain down to 7 words, then assert reset asynchronously mid-cycle.
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      exp_d = 8'h80 + 8'(i);
      check("pre_rst_data", bus.rd_data, exp_d);
    end
    check("pre_rst_count", bus.count, 7);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_pop_valid", bus.rd_valid, 0);
    check("post_rst_pop_count", bus.count, 0);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    check("post_rst_count", bus.count, 2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_d0", bus.rd_data, 8'h11);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_d1", bus.rd_data, 8'h22);
    check("post_rst_empty", bus.empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver. It captures each received word on the receiver's one-cycle done pulse, stores up to 2**ADDR_W words in order, and hands them to the consuming logic through a registered pop interface. It reports empty, full, almost-full and a sticky overflow flag so the consumer or a flow-control stage can throttle the remote transmitter.

## Interface
- DBIT, 8, data word width; matches the receiver's data width.
- ADDR_W, 4, address width; depth = 2**ADDR_W (16 by default).
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; legal range 1..2**ADDR_W.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_data  input  DBIT  word from receiver; sampled only when wr_tick=1.
- wr_tick  input  1  one-cycle push strobe (receiver done tick).
- rd_en  input  1  pop request; honoured only when empty=0.
- rd_data  output  DBIT  registered word from the last successful pop.
- rd_valid  output  1  one-cycle pulse, rd_data updated this cycle.
- empty  output  1  no words stored.
- full  output  1  2**ADDR_W words stored.
- almost_full  output  1  count >= AF_LEVEL.
- count  output  ADDR_W+1  number of stored words, 0..2**ADDR_W.
- overflow  output  1  sticky: a push was dropped.
- overflow_clr  input  1  clears overflow.

## Operation
- Storage: 2**ADDR_W x DBIT register array; write pointer wr_ptr and read pointer rd_ptr, each ADDR_W bits, wrap modulo 2**ADDR_W (15 -> 0 at default).
- Occupancy tracked by count (ADDR_W+1 bits); empty = (count==0), full = (count==2**ADDR_W), almost_full = (count>=AF_LEVEL), all decoded from registered count.
- Push accepted when wr_tick=1 and (full=0 or pop accepted same cycle): mem[wr_ptr] <= wr_data, wr_ptr++.
- Pop accepted when rd_en=1 and empty=0: rd_data <= mem[rd_ptr], rd_ptr++, rd_valid <= 1.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous events:
  - Full, push and pop: both accepted; count stays 2**ADDR_W; no overflow.
  - Empty, push and pop: push accepted, pop ignored (no bypass); rd_valid stays 0; count becomes 1.
  - Full, push without pop: word dropped, pointers and memory unchanged, overflow <= 1.
  - rd_en while empty: ignored, rd_data holds, rd_valid=0.
- overflow: set on dropped push, cleared by overflow_clr; set has priority when both occur in one cycle.
- rd_data holds its value between pops; never changes without rd_valid.
- Reset (asynchronous, any time incl. mid-stream): pointers=0, count=0, rd_data=0, rd_valid=0, overflow=0. Memory contents not reset. All in-flight words discarded.

## Timing
- Reset values: rd_data=0, rd_valid=0, empty=1, full=0, almost_full=0, count=0, overflow=0.
- Push latency: word pushed at edge N is visible in count/empty after edge N; poppable with rd_en in cycle N+1.
- Pop latency: rd_en sampled high at edge N -> rd_data and rd_valid valid after edge N (one cycle), rd_valid low after edge N+1 unless another pop.
- Back-to-back: one push and one pop per cycle sustained indefinitely.
- Flags are registered-derived; no combinational path from wr_tick or rd_en to any output.

## Test plan
- Reset then push 0x41,0x42,0x43 (one per 16 cycles) -> count=3, empty=0; pop three cycles in a row -> rd_data 0x41,0x42,0x43 with rd_valid each cycle, then empty=1, count=0.
- Push 16 words 0x00..0x0F -> almost_full rises at count=12, full=1 at 16; 17th push 0xFF -> dropped, overflow=1, count=16; pop all -> 0x00..0x0F, 0xFF never appears.
- Full, push 0xAA with rd_en same cycle -> rd_data=old head, count stays 16, overflow=0; 0xAA emerges last after draining.
- Empty, push 0x55 with rd_en same cycle -> rd_valid=0, count=1; next-cycle pop -> rd_data=0x55.
- Wrap-around: 40 push/pop pairs with varying lag -> output sequence equals input sequence; overflow_clr and drop in same cycle -> overflow stays 1, clr alone next cycle -> 0.
- Assert reset asynchronously mid-clock with count=7 -> all outputs to reset values immediately; post-reset pop ignored, new pushes read back correctly.
